// File: rtl/calculator_pkg.sv
// Shared definitions for the stream calculator controller.
//   DEF_DATA_W / DEF_ADDR_W : default operand and SRAM address widths
//   state_t                 : controller FSM states
//   op_mode_t               : arithmetic operation selector
package calculator_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_mode_t;

endpackage

// File: rtl/stream_calc_controller_if.sv
// Job-control and SRAM bus bundle for stream_calc_controller.
//   start_i, op_mode_i, *_addr_i : job launch and inclusive address ranges
//   read_n_o, r_addr_o, r_data_i : SRAM read port (active-low enable)
//   write_n_o, w_addr_o, w_data_o: SRAM write port (active-low enable)
//   busy_o, done_o, ovf_o, err_o : job status
// Modports: master = controller side, slave = host/SRAM side.
interface stream_calc_controller_if
  import calculator_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);
  localparam int unsigned MEM_W = 2 * DATA_W;

  logic              start_i;
  logic              op_mode_i;
  logic [ADDR_W-1:0] read_start_addr_i;
  logic [ADDR_W-1:0] read_end_addr_i;
  logic [ADDR_W-1:0] write_start_addr_i;
  logic [ADDR_W-1:0] write_end_addr_i;
  logic              read_n_o;
  logic [ADDR_W-1:0] r_addr_o;
  logic [MEM_W-1:0]  r_data_i;
  logic              write_n_o;
  logic [ADDR_W-1:0] w_addr_o;
  logic [MEM_W-1:0]  w_data_o;
  logic              busy_o;
  logic              done_o;
  logic              ovf_o;
  logic              err_o;

  modport master (
    input  start_i, op_mode_i, read_start_addr_i, read_end_addr_i,
           write_start_addr_i, write_end_addr_i, r_data_i,
    output read_n_o, r_addr_o, write_n_o, w_addr_o, w_data_o,
           busy_o, done_o, ovf_o, err_o
  );

  modport slave (
    output start_i, op_mode_i, read_start_addr_i, read_end_addr_i,
           write_start_addr_i, write_end_addr_i, r_data_i,
    input  read_n_o, r_addr_o, write_n_o, w_addr_o, w_data_o,
           busy_o, done_o, ovf_o, err_o
  );

endinterface

// File: rtl/calc_alu.sv
// Combinational add/subtract with signed-overflow detection.
//   a_i, b_i : operands
//   op_i     : OP_ADD -> a+b, OP_SUB -> a-b
//   res_o    : result (wraps; clamps to signed max/min when CALC_SATURATE_EN)
//   ovf_o    : signed overflow of the unclamped result
// Macro: CALC_SATURATE_EN enables saturation.
module calc_alu
  import calculator_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  op_mode_t          op_i,
  output logic [DATA_W-1:0] res_o,
  output logic              ovf_o
);

  logic [DATA_W-1:0] raw;
  logic              b_eff_sgn;

  always_comb begin
    raw       = (op_i == OP_SUB) ? (a_i - b_i) : (a_i + b_i);
    // Sign of the effective addend: subtraction adds -b.
    b_eff_sgn = (op_i == OP_SUB) ? ~b_i[DATA_W-1] : b_i[DATA_W-1];
    ovf_o     = (a_i[DATA_W-1] == b_eff_sgn) && (raw[DATA_W-1] != a_i[DATA_W-1]);
    res_o     = raw;
`ifdef CALC_SATURATE_EN
    // On overflow the true result has the sign of a.
    if (ovf_o) begin
      res_o = a_i[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
`else
`endif
  end

endmodule

// File: rtl/stream_calc_controller.sv
// Streams operand pairs from SRAM, applies add/sub, and packs two results
// per write word (lane 0 = lower half, lane 1 = upper half).
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : stream_calc_controller_if.master (job control, SRAM, status)
// Macro: CALC_SATURATE_EN (saturating results, passed through to calc_alu).
module stream_calc_controller
  import calculator_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input logic                      clk_i,
  input logic                      rst_i,
  stream_calc_controller_if.master bus
);

  localparam int unsigned MEM_W = 2 * DATA_W;
  localparam logic [ADDR_W:0] ONE = 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] rd_end_q, rd_end_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  op_mode_t          op_q, op_d;
  logic              lane_q, lane_d;
  logic              last_q, last_d;
  logic [MEM_W-1:0]  buf_q, buf_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic [ADDR_W:0]   n_rd, n_wr, words_req;
  logic              range_ok;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;

  calc_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i   (bus.r_data_i[MEM_W-1:DATA_W]),
    .b_i   (bus.r_data_i[DATA_W-1:0]),
    .op_i  (op_q),
    .res_o (alu_res),
    .ovf_o (alu_ovf)
  );

  // Extra bit keeps a full-span range (N = 2^ADDR_W) from wrapping.
  always_comb begin
    n_rd      = {1'b0, bus.read_end_addr_i} - {1'b0, bus.read_start_addr_i} + ONE;
    n_wr      = {1'b0, bus.write_end_addr_i} - {1'b0, bus.write_start_addr_i} + ONE;
    words_req = (n_rd + ONE) >> 1;
    range_ok  = (bus.read_end_addr_i >= bus.read_start_addr_i) &&
                (bus.write_end_addr_i >= bus.write_start_addr_i) &&
                (n_wr >= words_req);
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    rd_end_d = rd_end_q;
    wr_ptr_d = wr_ptr_q;
    op_d     = op_q;
    lane_d   = lane_q;
    last_d   = last_q;
    buf_d    = buf_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          ovf_d    = 1'b0;
          err_d    = ~range_ok;
          op_d     = op_mode_t'(bus.op_mode_i);
          rd_ptr_d = bus.read_start_addr_i;
          rd_end_d = bus.read_end_addr_i;
          wr_ptr_d = bus.write_start_addr_i;
          lane_d   = 1'b0;
          buf_d    = '0;
          state_d  = range_ok ? ST_READ : ST_DONE;
        end
      end
      ST_READ: begin
        // Capture "final read" here so EXEC/WRITE need no pointer compare
        // that could be fooled by the pointer wrapping at the top address.
        last_d   = (rd_ptr_q == rd_end_q);
        rd_ptr_d = rd_ptr_q + 1'b1;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        if (lane_q) buf_d[MEM_W-1:DATA_W] = alu_res;
        else        buf_d[DATA_W-1:0]     = alu_res;
        lane_d = ~lane_q;
        if (alu_ovf) ovf_d = 1'b1;
        state_d = (lane_q || last_q) ? ST_WRITE : ST_READ;
      end
      ST_WRITE: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        buf_d    = '0;
        lane_d   = 1'b0;
        state_d  = last_q ? ST_DONE : ST_READ;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      rd_end_q <= '0;
      wr_ptr_q <= '0;
      op_q     <= OP_ADD;
      lane_q   <= 1'b0;
      last_q   <= 1'b0;
      buf_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      rd_end_q <= rd_end_d;
      wr_ptr_q <= wr_ptr_d;
      op_q     <= op_d;
      lane_q   <= lane_d;
      last_q   <= last_d;
      buf_q    <= buf_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // Strobes decode straight from state so reset silences the SRAM at once.
  assign bus.read_n_o  = (state_q != ST_READ);
  assign bus.write_n_o = (state_q != ST_WRITE);
  assign bus.r_addr_o  = rd_ptr_q;
  assign bus.w_addr_o  = wr_ptr_q;
  assign bus.w_data_o  = buf_q;
  assign bus.busy_o    = (state_q == ST_READ) || (state_q == ST_EXEC) ||
                         (state_q == ST_WRITE);
  assign bus.done_o    = (state_q == ST_DONE);
  assign bus.ovf_o     = ovf_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_stream_calc_controller.sv
// Directed testbench for stream_calc_controller with a behavioural SRAM.
// Expected values are hand-computed constants.
module tb_stream_calc_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_calc_controller_if #(.DATA_W(32), .ADDR_W(10)) bus_if ();

  stream_calc_controller #(.DATA_W(32), .ADDR_W(10)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  // SRAM model: one-cycle read latency; tb preloads through the ld_* port.
  logic [63:0] mem [0:1023];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [63:0] ld_data = '0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          coll_cnt = 0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (!bus_if.read_n_o) begin
      bus_if.r_data_i <= mem[bus_if.r_addr_o];
      rd_cnt <= rd_cnt + 1;
    end
    if (!bus_if.write_n_o) begin
      mem[bus_if.w_addr_o] <= bus_if.w_data_o;
      wr_cnt <= wr_cnt + 1;
    end
    if (!bus_if.read_n_o && !bus_if.write_n_o) coll_cnt <= coll_cnt + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mem_load(input logic [9:0] a, input logic [63:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Launches a job and waits (bounded) for done_o. cyc counts edges after
  // the launch edge until done_o is seen; reaching the bound shows as a
  // cycle-count miscompare at the caller.
  task automatic run_job(input logic [9:0] rs, input logic [9:0] re,
                         input logic [9:0] ws, input logic [9:0] we, input logic op,
                         output int cyc, output int rds, output int wrs,
                         output logic done_after);
    int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    bus_if.read_start_addr_i  = rs;
    bus_if.read_end_addr_i    = re;
    bus_if.write_start_addr_i = ws;
    bus_if.write_end_addr_i   = we;
    bus_if.op_mode_i          = op;
    bus_if.start_i            = 1'b1;
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    cyc = 0;
    while (!bus_if.done_o && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    done_after = bus_if.done_o | bus_if.busy_o;
    rds = rd_cnt - rd0;
    wrs = wr_cnt - wr0;
  endtask

  int   cyc, rds, wrs, wr_snap;
  logic dflag;
  logic [63:0] exp_ovf_word, exp_sub_word;

  initial begin
    bus_if.start_i = 1'b0;
    bus_if.op_mode_i = 1'b0;
    bus_if.read_start_addr_i = '0;
    bus_if.read_end_addr_i = '0;
    bus_if.write_start_addr_i = '0;
    bus_if.write_end_addr_i = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_val("rst_outs", {bus_if.read_n_o, bus_if.write_n_o, bus_if.busy_o, bus_if.done_o,
                           bus_if.ovf_o, bus_if.err_o}, 64'b110000);
    check_val("rst_addrs", {bus_if.r_addr_o, bus_if.w_addr_o}, 64'h0);
    check_val("rst_wdata", bus_if.w_data_o, 64'h0);

    mem_load(10'd0, {32'd5, 32'd3});
    mem_load(10'd1, {32'd7, 32'd2});
    mem_load(10'd2, {32'd1, 32'd1});
    mem_load(10'd3, {32'd10, 32'd4});
    mem_load(10'd8, 64'hAAAA_AAAA_AAAA_AAAA);
    mem_load(10'd9, 64'hAAAA_AAAA_AAAA_AAAA);

    // Four reads, two packed writes.
    run_job(10'd0, 10'd3, 10'd8, 10'd9, 1'b0, cyc, rds, wrs, dflag);
    check_val("even_cycles", cyc, 10);
    check_val("even_mem8", mem[8], 64'h0000_0009_0000_0008);
    check_val("even_mem9", mem[9], 64'h0000_000E_0000_0002);
    check_val("even_reads", rds, 4);
    check_val("even_writes", wrs, 2);
    check_val("even_idle_after", dflag, 1'b0);
    check_val("even_flags", {bus_if.ovf_o, bus_if.err_o}, 2'b00);

    // Odd N: last word carries a zero upper half.
    mem_load(10'd9, 64'hAAAA_AAAA_AAAA_AAAA);
    run_job(10'd0, 10'd2, 10'd8, 10'd9, 1'b0, cyc, rds, wrs, dflag);
    check_val("odd_cycles", cyc, 8);
    check_val("odd_mem9", mem[9], 64'h0000_0000_0000_0002);
    check_val("odd_writes", wrs, 2);

`ifdef CALC_SATURATE_EN
    exp_ovf_word = 64'h0000_0000_7FFF_FFFF;
    exp_sub_word = 64'hFFFF_FFFE_8000_0000;
`else
    exp_ovf_word = 64'h0000_0000_8000_0000;
    exp_sub_word = 64'hFFFF_FFFE_7FFF_FFFF;
`endif

    // Positive add overflow, single-element job.
    mem_load(10'd20, {32'h7FFF_FFFF, 32'h0000_0001});
    run_job(10'd20, 10'd20, 10'd30, 10'd30, 1'b0, cyc, rds, wrs, dflag);
    check_val("ovf_add_cycles", cyc, 3);
    check_val("ovf_add_word", mem[30], exp_ovf_word);
    check_val("ovf_add_flag", bus_if.ovf_o, 1'b1);

    // Subtract: min-1 overflows (lane 0), 3-5 does not (lane 1).
    mem_load(10'd21, {32'h8000_0000, 32'h0000_0001});
    mem_load(10'd22, {32'd3, 32'd5});
    run_job(10'd21, 10'd22, 10'd31, 10'd31, 1'b1, cyc, rds, wrs, dflag);
    check_val("sub_cycles", cyc, 5);
    check_val("sub_word", mem[31], exp_sub_word);
    check_val("sub_ovf_flag", bus_if.ovf_o, 1'b1);

    // Clean job clears sticky overflow.
    run_job(10'd2, 10'd3, 10'd60, 10'd60, 1'b0, cyc, rds, wrs, dflag);
    check_val("clr_word", mem[60], 64'h0000_000E_0000_0002);
    check_val("clr_ovf_flag", bus_if.ovf_o, 1'b0);

    // Reversed read range.
    run_job(10'd5, 10'd2, 10'd8, 10'd9, 1'b0, cyc, rds, wrs, dflag);
    check_val("err_rev_cycles", cyc, 0);
    check_val("err_rev_flag", bus_if.err_o, 1'b1);
    check_val("err_rev_access", rds + wrs, 0);

    // Write range one word short.
    run_job(10'd0, 10'd3, 10'd8, 10'd8, 1'b0, cyc, rds, wrs, dflag);
    check_val("err_short_flag", bus_if.err_o, 1'b1);
    check_val("err_short_access", rds + wrs, 0);

    // Next valid job clears err_o.
    run_job(10'd0, 10'd0, 10'd61, 10'd61, 1'b0, cyc, rds, wrs, dflag);
    check_val("err_clr_word", mem[61], 64'h0000_0000_0000_0008);
    check_val("err_clr_flag", bus_if.err_o, 1'b0);

    // Reset while lane 1 of the second pair is being computed.
    mem_load(10'd41, 64'h5555_5555_5555_5555);
    wr_snap = wr_cnt;
    bus_if.read_start_addr_i  = 10'd0;
    bus_if.read_end_addr_i    = 10'd3;
    bus_if.write_start_addr_i = 10'd40;
    bus_if.write_end_addr_i   = 10'd41;
    bus_if.op_mode_i          = 1'b0;
    bus_if.start_i            = 1'b1;
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_val("mid_busy", {bus_if.busy_o, bus_if.read_n_o, bus_if.write_n_o}, 3'b111);
    rst = 1'b1;
    #1;
    check_val("mid_rst_outs", {bus_if.read_n_o, bus_if.write_n_o, bus_if.busy_o, bus_if.done_o,
                               bus_if.ovf_o, bus_if.err_o}, 64'b110000);
    check_val("mid_rst_addrs", {bus_if.r_addr_o, bus_if.w_addr_o}, 64'h0);
    check_val("mid_rst_wdata", bus_if.w_data_o, 64'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("mid_writes", wr_cnt - wr_snap, 1);
    check_val("mid_mem41", mem[41], 64'h5555_5555_5555_5555);
    check_val("mid_mem40", mem[40], 64'h0000_0009_0000_0008);

    run_job(10'd0, 10'd3, 10'd50, 10'd51, 1'b0, cyc, rds, wrs, dflag);
    check_val("rec_cycles", cyc, 10);
    check_val("rec_mem50", mem[50], 64'h0000_0009_0000_0008);
    check_val("rec_mem51", mem[51], 64'h0000_000E_0000_0002);
    check_val("rec_writes", wrs, 2);

    check_val("strobe_overlap", coll_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_calc_controller.md
STREAM_CALC_CONTROLLER -- requirements
Module: stream_calc_controller

Interface
REQ-001 Parameter DATA_W, 32, operand/result width; SRAM word width is MEM_W = 2*DATA_W.
REQ-002 Parameter ADDR_W, 10, SRAM address width.
REQ-003 Port clk_i, in, 1, the single clock.
REQ-004 Port rst_i, in, 1, reset, asynchronous and active-high.
REQ-005 Port start_i, in, 1, single-cycle job launch pulse.
REQ-006 Port op_mode_i, in, 1, operation (0 = add, 1 = subtract a-b), sampled at start.
REQ-007 Ports read_start_addr_i, read_end_addr_i, write_start_addr_i, write_end_addr_i, in, ADDR_W each, inclusive address ranges sampled at start.
REQ-008 Port read_n_o, out, 1, SRAM read enable, active-low.
REQ-009 Port r_addr_o, out, ADDR_W, SRAM read address.
REQ-010 Port r_data_i, in, MEM_W, read word; operand a = upper DATA_W bits, operand b = lower DATA_W bits.
REQ-011 Port write_n_o, out, 1, SRAM write enable, active-low.
REQ-012 Port w_addr_o, out, ADDR_W, SRAM write address.
REQ-013 Port w_data_o, out, MEM_W, packed result word.
REQ-014 Ports busy_o, done_o, ovf_o, err_o, out, 1 each: job active, job-complete pulse, sticky overflow, sticky range error.

Function
REQ-015 States IDLE, READ, EXEC, WRITE, DONE; one state per cycle.
REQ-016 IDLE: start_i -> READ if ranges valid; else err_o set, DONE; start_i ignored in all other states.
REQ-017 Range valid SHALL mean read_end >= read_start, write_end >= write_start, and write range holds ceil(N/2) words, N = read_end-read_start+1.
REQ-018 READ drives read_n_o=0 with r_addr_o = current read pointer; r_data_i is valid in the following cycle (EXEC); read pointer increments on leaving READ.
REQ-019 EXEC computes a op b modulo 2^DATA_W, stores result in lane 0 (lower half) if lane toggle = 0, else lane 1 (upper half), then toggles lane.
REQ-020 EXEC -> WRITE if lane 1 was just filled or the last read was processed; else -> READ.
REQ-021 WRITE drives write_n_o=0, w_addr_o = write pointer, w_data_o = packed buffer; write pointer increments; buffer clears to zero afterwards.
REQ-022 Odd N: final word written with upper half zero.
REQ-023 WRITE -> DONE after last word, else -> READ; full pair costs 5 cycles.
REQ-024 DONE pulses done_o for one cycle, -> IDLE; busy_o high in READ, EXEC, WRITE.
REQ-025 ovf_o sets on signed overflow of any result; ovf_o and err_o clear on next accepted start_i.
REQ-026 read_n_o and write_n_o are never low in the same cycle; both high outside READ/WRITE.

Reset
REQ-027 rst_i asserted forces state IDLE immediately, including mid-job; no further SRAM access occurs.
REQ-028 Reset values: read_n_o=1, write_n_o=1, r_addr_o=0, w_addr_o=0, w_data_o=0, busy_o=0, done_o=0, ovf_o=0, err_o=0, lane toggle=0.

Configuration
REQ-029 Macro CALC_SATURATE_EN defined: overflowing results clamp to signed max/min; undefined: results wrap; ovf_o behaves identically in both.

Structure
REQ-030 calculator_pkg holds DATA_W/ADDR_W defaults, the state enum, and the op-mode enum.
REQ-031 One sub-module calc_alu (combinational add/sub, overflow flag, optional saturation).

Verification
REQ-032 Reads 0..3 = {a=5,b=3},{7,2},{1,1},{10,4}, add, write 8..9 -> addr8=0x0000_0009_0000_0008, addr9=0x0000_000E_0000_0002, done_o pulse, 10 write_n_o... exactly 2 write strobes.
REQ-033 Odd N=3 same data -> addr9=0x0000_0000_0000_0002, done_o after third result.
REQ-034 a=0x7FFF_FFFF, b=1, add -> ovf_o=1; result 0x8000_0000 without CALC_SATURATE_EN, 0x7FFF_FFFF with it.
REQ-035 read_end=2, read_start=5 -> err_o=1, done_o pulse, no read_n_o/write_n_o low.
REQ-036 rst_i asserted in EXEC of second pair -> all outputs at reset values in the same cycle; new start_i runs a full clean job.
